// File: rtl/burst_mem_responder_pkg.sv
// Shared types and constants for the cache-line burst memory responder.
// A line is four 64-bit beats; the low OFFSET_W address bits select bytes within it.
package burst_mem_types;

    localparam int BEAT_W   = 64;
    localparam int BEATS    = 4;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } bm_state_t;

    function automatic logic [1:0] next_beat(input logic [1:0] beat);
        return beat + 2'd1;
    endfunction

endpackage

// File: rtl/burst_mem_responder_beat_ram.sv
// Single-port synchronous beat RAM: one registered read or one write per cycle.
// Contents are deliberately left unreset so the array maps onto block RAM.
module beat_ram
    import burst_mem_types::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BEAT_W-1:0] wdata,
    output logic [BEAT_W-1:0] rdata
);

    logic [BEAT_W-1:0] mem_q [0:(2**ADDR_W)-1];
    logic [BEAT_W-1:0] rdata_q;

    // Write port, or registered read when not writing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the cache-line burst port: one 256-bit line per request,
// delivered as four 64-bit beats after a programmable latency.
module burst_mem_responder
    import burst_mem_types::*;
#(
    parameter int LINE_IDX_W = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [BEAT_W-1:0] mem_wdata,
    output logic [BEAT_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              busy,
    output logic              protocol_err
);

    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int RAM_AW = LINE_IDX_W + 2;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

    bm_state_t         state_q, state_d;
    logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [1:0]        beat_q, beat_d;
    logic              is_write_q, is_write_d;
    logic [31:0]       addr_q, addr_d;
    logic              err_q, err_d;
    logic              resp_q, resp_d;
    logic              busy_q, busy_d;

    logic              violation_s;
    logic              ram_we_s;
    logic [RAM_AW-1:0] ram_addr_s;
    logic [BEAT_W-1:0] ram_rdata_s;
    logic [LINE_IDX_W-1:0] req_line_s;
    logic [LINE_IDX_W-1:0] line_s;

    assign req_line_s = mem_addr[OFFSET_W +: LINE_IDX_W];
    assign line_s     = addr_q[OFFSET_W +: LINE_IDX_W];

    // The initiator must hold the exact request it started with until the burst ends.
    assign violation_s = (mem_read == is_write_q) || (mem_write != is_write_q) || (mem_addr != addr_q);

    // Next-state, counters, request latches and sticky error.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        beat_d     = beat_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (mem_read && mem_write) begin
                    err_d = 1'b1;
                end else if (mem_read || mem_write) begin
                    is_write_d = mem_write;
                    addr_d     = mem_addr;
                    lat_cnt_d  = LAT_LOAD;
                    beat_d     = 2'd0;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d = BURST;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (violation_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (lat_cnt_q <= CNT_W'(1)) begin
                    lat_cnt_d = {CNT_W{1'b0}};
                    state_d   = BURST;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end
            end
            BURST: begin
                if (violation_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                beat_d = next_beat(beat_q);
                if (beat_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    state_d = BURST;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        resp_d = (state_d == BURST);
        busy_d = (state_d != IDLE);
    end

    // RAM port: reads run one beat ahead of the response so data is ready on each resp cycle.
    always_comb begin
        ram_we_s   = 1'b0;
        ram_addr_s = {line_s, 2'd0};
        case (state_q)
            IDLE: begin
                ram_addr_s = {req_line_s, 2'd0};
            end
            WAIT: begin
                ram_addr_s = {line_s, 2'd0};
            end
            BURST: begin
                if (is_write_q) begin
                    ram_we_s   = 1'b1;
                    ram_addr_s = {line_s, beat_q};
                end else begin
                    ram_addr_s = {line_s, next_beat(beat_q)};
                end
            end
            DONE: begin
                ram_addr_s = {line_s, 2'd0};
            end
            default: begin
                ram_addr_s = {line_s, 2'd0};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_cnt_q  <= {CNT_W{1'b0}};
            beat_q     <= 2'd0;
            is_write_q <= 1'b0;
            addr_q     <= 32'd0;
            err_q      <= 1'b0;
            resp_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            beat_q     <= beat_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            resp_q     <= resp_d;
            busy_q     <= busy_d;
        end
    end

    beat_ram #(
        .ADDR_W (RAM_AW)
    ) u_beat_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (mem_wdata),
        .rdata (ram_rdata_s)
    );

    // The RAM output register has no reset, so data is masked outside resp cycles.
    assign mem_rdata    = resp_q ? ram_rdata_s : {BEAT_W{1'b0}};
    assign mem_resp     = resp_q;
    assign busy         = busy_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Randomized self-checking bench: two responders (latency 4 and latency 1) checked
// cycle by cycle against a line-granular memory model.
module tb_burst_mem_responder;

    localparam int IDX_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        rd, wr, resp, busy, perr;
    logic [1:0][31:0]  addr;
    logic [1:0][63:0]  wdata, rdata;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chained = 1'b0;
    logic [255:0] model [int];
    logic [31:0]  pool [8];

    always #5 clk = ~clk;

    burst_mem_responder #(.LINE_IDX_W(IDX_W), .LATENCY(4)) u_dut0 (
        .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_resp(resp[0]), .busy(busy[0]),
        .protocol_err(perr[0]));

    burst_mem_responder #(.LINE_IDX_W(IDX_W), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_resp(resp[1]), .busy(busy[1]),
        .protocol_err(perr[1]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", tag, $time, obs, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int key_of(input int d, input logic [31:0] a);
        return d * 4096 + int'((a / 32'd32) % 32'(1 << IDX_W));
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // mode: 0 normal, 1 hold request into IDLE, 2 drop request in WAIT,
    //       3 leave request up for a back-to-back follower, 4 reset during beat 2 of a write
    task automatic burst(input int d, input bit we, input logic [31:0] a,
                         input logic [255:0] wline, input int mode);
        int L;
        int k;
        int key;
        int last;
        logic [255:0] expl;
        logic [255:0] old;
        L   = lat_of(d);
        k   = 0;
        key = key_of(d, a);
        old = model.exists(key) ? model[key] : 256'd0;
        expl = old;
        if (!chained) @(negedge clk);
        chained  = 1'b0;
        rd[d]    = !we;
        wr[d]    = we;
        addr[d]  = a;
        wdata[d] = wline[63:0];
        @(posedge clk);
        last = (mode == 3 || mode == 1) ? L + 5 : L + 6;
        for (int j = 1; j <= last; j++) begin
            @(negedge clk);
            chk("resp", resp[d], (j >= L && j <= L + 3));
            chk("busy", busy[d], (j <= L + 4));
            if (resp[d]) begin
                if (!we) chk("rdata", rdata[d], expl[k*64 +: 64]);
                else wdata[d] = wline[k*64 +: 64];
                k++;
            end
            if (mode == 4 && k == 3) begin
                rst = 1'b1;
                #1;
                chk("rst_resp", resp[d], 1'b0);
                chk("rst_busy", busy[d], 1'b0);
                chk("rst_rdata", rdata[d], 64'd0);
                rd[d] = 1'b0;
                wr[d] = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (mode == 2 && j == 1) begin
                rd[d] = 1'b0;
                wr[d] = 1'b0;
            end
            if (((mode == 0 || mode == 2) && j == L + 4) || (mode == 1 && j == L + 5)) begin
                rd[d] = 1'b0;
                wr[d] = 1'b0;
            end
        end
        if (mode != 4) chk("beats", 64'(k), 64'd4);
        if (we && mode == 4) model[key] = {old[255:128], wline[127:0]};
        else if (we) model[key] = wline;
        chained = (mode == 3);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("perr_clr0", perr[0], 1'b0);
        chk("perr_clr1", perr[1], 1'b0);
    endtask

    initial begin
        logic [255:0] line_v;
        logic [255:0] old_v;
        logic [31:0]  a;
        int d;
        bit we;
        rst   = 1'b1;
        rd    = 2'b00;
        wr    = 2'b00;
        addr  = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_resp", resp[i], 1'b0);
            chk("reset_busy", busy[i], 1'b0);
            chk("reset_perr", perr[i], 1'b0);
            chk("reset_rdata", rdata[i], 64'd0);
        end
        rst = 1'b0;

        line_v = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        burst(0, 1'b1, 32'h0000_0100, line_v, 0);
        burst(0, 1'b0, 32'h0000_0100, 256'd0, 0);
        burst(0, 1'b1, 32'h0000_8000, rand_line(), 0);
        burst(0, 1'b0, 32'h0000_0000, 256'd0, 0);
        burst(0, 1'b0, 32'h0000_0110, 256'd0, 0);
        burst(0, 1'b0, 32'h0000_0100, 256'd0, 1);
        chk("held_perr", perr[0], 1'b0);

        for (int i = 0; i < 8; i++) pool[i] = 32'($urandom_range(0, 1023)) << 5;
        for (int i = 0; i < 40; i++) begin
            d  = int'($urandom_range(0, 1));
            a  = pool[$urandom_range(0, 7)] + (32'($urandom_range(0, 3)) << 15) + 32'($urandom_range(0, 31));
            we = ($urandom_range(0, 1) == 1) || !model.exists(key_of(d, a));
            burst(d, we, a, rand_line(), 0);
        end
        chk("rand_perr0", perr[0], 1'b0);
        chk("rand_perr1", perr[1], 1'b0);

        burst(1, 1'b1, 32'h0000_0200, rand_line(), 0);
        burst(1, 1'b1, 32'h0000_0220, rand_line(), 0);
        burst(1, 1'b0, 32'h0000_0200, 256'd0, 3);
        burst(1, 1'b0, 32'h0000_0220, 256'd0, 0);
        chk("b2b_perr", perr[1], 1'b0);

        @(negedge clk);
        rd[0]   = 1'b1;
        wr[0]   = 1'b1;
        addr[0] = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("both_resp", resp[0], 1'b0);
            chk("both_busy", busy[0], 1'b0);
        end
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        chk("both_perr", perr[0], 1'b1);
        chk("both_perr_other", perr[1], 1'b0);
        reset_pulse();

        burst(0, 1'b0, 32'h0000_0100, 256'd0, 2);
        chk("drop_perr", perr[0], 1'b1);
        reset_pulse();

        old_v = rand_line();
        burst(0, 1'b1, 32'h0000_0300, old_v, 0);
        burst(0, 1'b1, 32'h0000_0300, rand_line(), 4);
        chk("midrst_perr", perr[0], 1'b0);
        burst(0, 1'b0, 32'h0000_0300, 256'd0, 0);
        chk("midrst_old_hi", model[key_of(0, 32'h0000_0300)][255:192], old_v[255:192]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/burst_mem_responder.md
# burst_mem_responder

Synthesizable responder for the processor's cache-line burst memory port. It is the memory side of the `mem_read`/`mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata`/`mem_resp` interface that `mp4` drives. Each request transfers one 256-bit line as four 64-bit beats, backed by an on-chip RAM with a programmable access latency. It replaces the behavioural burst memory for FPGA and system-level runs.

## Interface
Parameters:
- `LINE_IDX_W`, default 10: number of line-index bits. Capacity is 2^LINE_IDX_W lines of 32 B.
- `LATENCY`, default 4: cycles from request acceptance to the first `mem_resp`. Minimum 1.

Ports (clock and reset first):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  line read request, held until the burst completes.
- `mem_write`  in  1  line write request, held until the burst completes.
- `mem_addr`  in  32  line address. Bits [4:0] are ignored; bits above 5+LINE_IDX_W are ignored, so addresses wrap.
- `mem_wdata`  in  64  current write beat. The initiator advances to the next beat after each `mem_resp`.
- `mem_rdata`  out  64  read beat, valid only while `mem_resp`=1.
- `mem_resp`  out  1  beat strobe, high for exactly 4 consecutive cycles per burst.
- `busy`  out  1  high in any state other than IDLE.
- `protocol_err`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- **FSM states:** IDLE → WAIT → BURST → DONE → IDLE.
- **IDLE:** sample at each rising edge.
  - Exactly one of `mem_read`/`mem_write` high: latch the request type and line index, load the latency counter with LATENCY-1, go to WAIT (or straight to BURST if LATENCY=1).
  - Both high: set `protocol_err`, ignore the request, stay in IDLE.
- **WAIT:** decrement the counter; go to BURST when it reaches 0.
- **BURST:**
  - `mem_resp`=1 with beat counter k = 0..3.
  - Read: `mem_rdata` = line[64k+63:64k].
  - Write: `mem_wdata` is captured into beat k at the edge that ends resp cycle k.
  - After k=3, go to DONE.
- **DONE:** one cycle with `mem_resp`=0 and requests ignored, so a request still held from the previous burst is never re-accepted. Then return to IDLE.
- **Mid-burst protocol violations:** if the request deasserts, the type flips, or `mem_addr` changes during WAIT or BURST:
  - set `protocol_err`;
  - the burst still completes on the latched line and type.
- **Coherence:** a read that follows a write to the same line returns the new data.
- **RAM contents:** not affected by reset and uninitialized after power-up.

## Timing
- **Reset values:** `mem_resp`=0, `mem_rdata`=0, `busy`=0, `protocol_err`=0, state=IDLE, counters=0.
- **Read or write accepted at edge t:**
  - `mem_resp` is high during cycles t+LATENCY through t+LATENCY+3.
  - DONE occupies cycle t+LATENCY+4.
  - The next request can be accepted at edge t+LATENCY+5 at the earliest.
- **Throughput:** LATENCY+5 cycles per line.
- **`mem_rdata`:** registered; it changes only on clock edges.
- **RAM read timing:** the synchronous RAM is read one cycle ahead of each beat. The address for beat k+1 is issued during beat k, and beat 0 is issued on the last WAIT cycle (or at acceptance when LATENCY=1).
- **Reset asserted mid-burst:**
  - all outputs return to their reset values immediately (asynchronous);
  - beats already written stay in the RAM; the remaining beats are not written.

## Structure
- **Package `burst_mem_types`:**
  - constants BEAT_W=64, BEATS=4, LINE_W=256, OFFSET_W=5;
  - state enum `bm_state_t` {IDLE, WAIT, BURST, DONE}.
- **Sub-module `beat_ram`:** single-port synchronous RAM, 64-bit wide, depth 4·2^LINE_IDX_W.
  - Address = {line index, beat}.
  - One read or one write per cycle.
  - No reset.
- **Top level:** contains the FSM, the latency counter, the 2-bit beat counter, request latches and error detection.

## Test plan
- **Write then read:** write line 0x100 with beats 0x1111…, 0x2222…, 0x3333…, 0x4444…, then read 0x100 → the same four beats in order, with `mem_resp` exactly 4 cycles starting LATENCY cycles after acceptance.
- **Wrap-around:** with LINE_IDX_W=10, write to 0x0000_8000, then read 0x0000_0000 → same data. Reading 0x0000_0110 returns line 0x100 (offset bits ignored).
- **Held request:** keep `mem_read` high for 2 cycles after the last resp → no second burst starts, `busy` falls after DONE, and no error is flagged.
- **Protocol errors:**
  - `mem_read` and `mem_write` both high in IDLE → `protocol_err`=1 and no resp;
  - `mem_read` dropped during WAIT → the burst completes and `protocol_err`=1.
- **Reset mid-burst:** assert `rst` after beat 1 of a write → `mem_resp` drops immediately. A later read shows beats 0–1 new and beats 2–3 old.
- **Minimum latency:** with LATENCY=1, back-to-back reads of lines 0x200 and 0x220 → resp at t+1..t+4, next acceptance at t+6, correct data in both bursts.
